// File: rtl/phase_scheduler.sv
// Two-road green/yellow phase scheduler feeding the light FSM's direction input.
// Timed or demand-driven in auto mode, follows manual_dir_i in manual mode.
module phase_scheduler #(
    parameter int TICK_DIV      = 1,
    parameter int GREEN_A_SEC   = 9,
    parameter int GREEN_B_SEC   = 9,
    parameter int MIN_GREEN_SEC = 3,
    parameter int YELLOW_CYC    = 5
) (
    input  logic       clk_f,
    input  logic       rst_i,
    input  logic       auto_en_i,
    input  logic       manual_dir_i,
    input  logic       veh_req_A_i,
    input  logic       veh_req_B_i,
    output logic       dir_o,
    output logic       sec_tick_o,
    output logic [3:0] remain_o,
    output logic [1:0] state_o,
    output logic       switch_o
);

    typedef enum logic [1:0] {
        ST_GRN_A  = 2'b00,
        ST_YEL_AB = 2'b01,
        ST_GRN_B  = 2'b10,
        ST_YEL_BA = 2'b11
    } state_t;

    localparam logic [15:0] PRESC_MAX  = 16'(TICK_DIV - 1);
    localparam logic [3:0]  GREEN_A_LD = 4'(GREEN_A_SEC);
    localparam logic [3:0]  GREEN_B_LD = 4'(GREEN_B_SEC);
    localparam logic [3:0]  CUT_A      = 4'(GREEN_A_SEC - MIN_GREEN_SEC);
    localparam logic [3:0]  CUT_B      = 4'(GREEN_B_SEC - MIN_GREEN_SEC);
    localparam logic [3:0]  YEL_LD     = 4'(YELLOW_CYC - 1);

    state_t      r_state;
    logic        r_dir;
    logic [3:0]  r_remain;
    logic [3:0]  r_ycnt;
    logic        r_switch;
    logic [15:0] r_presc;

    state_t      w_state_nxt;
    logic [3:0]  w_remain_nxt;
    logic [3:0]  w_ycnt_nxt;
    logic        w_switch;
    logic        w_tick;
    logic [3:0]  w_rem_dec;
    logic        w_own_req;
    logic        w_oth_req;
    logic [3:0]  w_cut_lim;
    logic        w_expire;
    logic        w_early;

    assign w_tick    = (r_presc == PRESC_MAX);
    assign w_rem_dec = (r_remain != 4'd0) ? (r_remain - 4'd1) : 4'd0;

    // "Own" road is the one currently green; in yellow states these are unused.
    assign w_own_req = (r_state == ST_GRN_B) ? veh_req_B_i : veh_req_A_i;
    assign w_oth_req = (r_state == ST_GRN_B) ? veh_req_A_i : veh_req_B_i;
    assign w_cut_lim = (r_state == ST_GRN_B) ? CUT_B : CUT_A;

    // Expiry looks at the current count; the early cut looks at the count this
    // tick produces, so minimum green ends on the tick that reaches the limit.
    assign w_expire = (r_remain == 4'd0) && !(w_own_req && !w_oth_req);
    assign w_early  = w_oth_req && !w_own_req && (w_rem_dec <= w_cut_lim);

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_ycnt_nxt   = r_ycnt;
        w_switch     = 1'b0;
        case (r_state)
            ST_GRN_A, ST_GRN_B: begin
                if (!auto_en_i) begin
                    w_switch = (manual_dir_i != r_dir);
                end else if (w_tick) begin
                    w_remain_nxt = w_rem_dec;
                    w_switch     = w_expire || w_early;
                end
                if (w_switch) begin
                    w_state_nxt = (r_state == ST_GRN_A) ? ST_YEL_AB : ST_YEL_BA;
                    w_ycnt_nxt  = YEL_LD;
                end
            end
            ST_YEL_AB, ST_YEL_BA: begin
                if (r_ycnt == 4'd0) begin
                    w_state_nxt  = (r_state == ST_YEL_AB) ? ST_GRN_B : ST_GRN_A;
                    w_remain_nxt = (r_state == ST_YEL_AB) ? GREEN_B_LD : GREEN_A_LD;
                end else begin
                    w_ycnt_nxt = r_ycnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_GRN_A;
        endcase
    end

    always_ff @(posedge clk_f) begin
        if (!rst_i) begin
            r_state  <= ST_GRN_A;
            r_dir    <= 1'b0;
            r_remain <= GREEN_A_LD;
            r_ycnt   <= 4'd0;
            r_switch <= 1'b0;
            r_presc  <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= r_dir ^ w_switch;
            r_remain <= w_remain_nxt;
            r_ycnt   <= w_ycnt_nxt;
            r_switch <= w_switch;
            r_presc  <= w_tick ? 16'd0 : (r_presc + 16'd1);
        end
    end

    // Gated so a TICK_DIV of 1 still shows no tick while reset is held.
    assign sec_tick_o = w_tick && rst_i;
    assign dir_o      = r_dir;
    assign remain_o   = r_remain;
    assign state_o    = r_state;
    assign switch_o   = r_switch;

endmodule
